// File: rtl/dma_way_mask_pkg.sv
// Shared constants, types and helpers for the DMA beat counter / way-mask block.
// Optional saturating count: define DMA_WAY_MASK_COUNTER_SATURATE_EN.
package dma_way_mask_pkg;

  localparam int DMA_BURST_LEN_DEF  = 4;
  localparam int WAYS_DEF           = 4;
  localparam int BYTES_PER_LANE_DEF = 8;

  // Width helper that never returns 0, so single-value fields still get a bit.
  function automatic int safe_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  typedef logic [WAYS_DEF-1:0][BYTES_PER_LANE_DEF-1:0] way_mask_t;

endpackage

// File: rtl/way_mask_expand.sv
// Replicates each input bit expand_p times; bit w lands in out[w*expand_p +: expand_p].
module way_mask_expand #(
  parameter int in_width_p = 4,
  parameter int expand_p   = 8
) (
  input  logic [in_width_p-1:0]          in_i,
  output logic [in_width_p*expand_p-1:0] out_o
);

  for (genvar w = 0; w < in_width_p; w++) begin : g_lane
    assign out_o[w*expand_p +: expand_p] = {expand_p{in_i[w]}};
  end

endmodule

// File: rtl/dma_way_mask_counter.sv
// Burst beat counter with fill/evict end flags plus one-hot way decode and byte-lane mask.
// Define DMA_WAY_MASK_COUNTER_SATURATE_EN to hold at max_val_p instead of wrapping.
module dma_way_mask_counter
  import dma_way_mask_pkg::*;
#(
  parameter  int max_val_p  = DMA_BURST_LEN_DEF,
  parameter  int init_val_p = 0,
  parameter  int ways_p     = WAYS_DEF,
  parameter  int expand_p   = BYTES_PER_LANE_DEF,
  localparam int cw         = safe_clog2(max_val_p + 1),
  localparam int lw         = safe_clog2(ways_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,
  input  logic                       up_i,
  output logic [cw-1:0]              count_o,
  output logic                       last_o,
  output logic                       max_o,
  input  logic [lw-1:0]              way_i,
  output logic [ways_p-1:0]          way_onehot_o,
  output logic [ways_p*expand_p-1:0] way_mask_o
);

  localparam logic [cw-1:0] INIT_VAL = cw'(init_val_p);
  localparam logic [cw-1:0] MAX_VAL  = cw'(max_val_p);

  logic [cw-1:0] count_q, count_d, base;

  // clear+up is the evict-start case (init+1); only a plain up at max overflows.
  always_comb begin
    base    = clear_i ? INIT_VAL : count_q;
    count_d = base;
    if (up_i) begin
      if (!clear_i && (count_q == MAX_VAL)) begin
`ifdef DMA_WAY_MASK_COUNTER_SATURATE_EN
        count_d = MAX_VAL;
`else
        count_d = '0;
`endif
      end else begin
        count_d = base + cw'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= INIT_VAL;
    else            count_q <= count_d;
  end

  assign count_o = count_q;
  assign max_o   = (count_q == MAX_VAL);

  if (max_val_p == 0) begin : g_no_last
    assign last_o = 1'b0;
  end else begin : g_last
    assign last_o = (count_q == cw'(max_val_p - 1));
  end

  // Out-of-range way indices match no lane and give an all-zero decode.
  for (genvar w = 0; w < ways_p; w++) begin : g_dec
    assign way_onehot_o[w] = (way_i == lw'(w));
  end

  way_mask_expand #(
    .in_width_p (ways_p),
    .expand_p   (expand_p)
  ) u_expand (
    .in_i  (way_onehot_o),
    .out_o (way_mask_o)
  );

endmodule

// File: tb/tb_dma_way_mask_counter.sv
// Self-checking bench: counter sequence table via scoreboard, way decode tables, reset corners.
module tb_dma_way_mask_counter;
  import dma_way_mask_pkg::*;

`ifdef DMA_WAY_MASK_COUNTER_SATURATE_EN
  localparam int  OVF_CNT = 4;
  localparam bit  OVF_MAX = 1'b1;
`else
  localparam int  OVF_CNT = 0;
  localparam bit  OVF_MAX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        up = 1'b0;
  logic [1:0]  way0 = '0;
  logic [1:0]  way1 = '0;
  logic [2:0]  cnt0, cnt1;
  logic        last0, max0, last1, max1;
  logic [3:0]  oh0;
  way_mask_t   mask0;
  logic [2:0]  oh1;
  logic [23:0] mask1;

  always #5 clk = ~clk;

  dma_way_mask_counter u_dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .up_i(up),
    .count_o(cnt0), .last_o(last0), .max_o(max0),
    .way_i(way0), .way_onehot_o(oh0), .way_mask_o(mask0)
  );

  dma_way_mask_counter #(.ways_p(3)) u_dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .up_i(up),
    .count_o(cnt1), .last_o(last1), .max_o(max1),
    .way_i(way1), .way_onehot_o(oh1), .way_mask_o(mask1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit    clr;
    bit    up;
    int    cnt;
    bit    last;
    bit    mx;
    string nm;
  } cnt_vec_t;

  typedef struct {
    int    cnt;
    bit    last;
    bit    mx;
    string nm;
  } exp_t;

  typedef struct {
    int    way;
    int    oh;
    int    mask;
  } way_vec_t;

  exp_t sb_q[$];

  // Expected result is queued when stimulus goes out and retired after the edge.
  task automatic step(input cnt_vec_t v);
    exp_t e;
    clear = v.clr;
    up    = v.up;
    sb_q.push_back('{v.cnt, v.last, v.mx, v.nm});
    @(posedge clk);
    #1;
    clear = 1'b0;
    up    = 1'b0;
    if (sb_q.size() == 0) begin
      chk({v.nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.nm, "_count"}, 32'(cnt0), 32'(e.cnt));
      chk({e.nm, "_last"},  32'(last0), 32'(e.last));
      chk({e.nm, "_max"},   32'(max0), 32'(e.mx));
    end
  endtask

  cnt_vec_t cvec[$];
  way_vec_t wvec0[$];
  way_vec_t wvec1[$];

  initial begin
    cvec = '{
      '{1'b0, 1'b1, 1, 1'b0, 1'b0, "up1"},
      '{1'b0, 1'b1, 2, 1'b0, 1'b0, "up2"},
      '{1'b0, 1'b1, 3, 1'b1, 1'b0, "up3_last"},
      '{1'b0, 1'b1, 4, 1'b0, 1'b1, "up4_max"},
      '{1'b1, 1'b1, 1, 1'b0, 1'b0, "clr_up"},
      '{1'b1, 1'b0, 0, 1'b0, 1'b0, "clr_only"},
      '{1'b0, 1'b0, 0, 1'b0, 1'b0, "hold"},
      '{1'b0, 1'b1, 1, 1'b0, 1'b0, "re_up1"},
      '{1'b0, 1'b1, 2, 1'b0, 1'b0, "re_up2"},
      '{1'b0, 1'b1, 3, 1'b1, 1'b0, "re_up3"},
      '{1'b0, 1'b1, 4, 1'b0, 1'b1, "re_up4"},
      '{1'b0, 1'b0, 4, 1'b0, 1'b1, "hold_max"},
      '{1'b0, 1'b1, OVF_CNT, 1'b0, OVF_MAX, "overflow"},
      '{1'b1, 1'b0, 0, 1'b0, 1'b0, "clr_after_ovf"}
    };
    wvec0 = '{
      '{0, 4'b0001, 32'h0000_00FF},
      '{1, 4'b0010, 32'h0000_FF00},
      '{2, 4'b0100, 32'h00FF_0000},
      '{3, 4'b1000, 32'hFF00_0000}
    };
    wvec1 = '{
      '{3, 3'b000, 24'h00_0000},
      '{2, 3'b100, 24'hFF_0000},
      '{0, 3'b001, 24'h00_00FF}
    };

    // Reset state, and combinational decode while reset is held.
    #2;
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_last",  32'(last0), 32'd0);
    chk("rst_max",   32'(max0), 32'd0);
    way0 = 2'd1;
    #1;
    chk("rst_onehot", 32'(oh0), 32'h2);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (cvec[i]) step(cvec[i]);

    foreach (wvec0[i]) begin
      way0 = 2'(wvec0[i].way);
      #1;
      chk($sformatf("onehot_w%0d", wvec0[i].way), 32'(oh0), 32'(wvec0[i].oh));
      chk($sformatf("mask_w%0d", wvec0[i].way), 32'(mask0), 32'(wvec0[i].mask));
    end
    foreach (wvec1[i]) begin
      way1 = 2'(wvec1[i].way);
      #1;
      chk($sformatf("w3_onehot_w%0d", wvec1[i].way), 32'(oh1), 32'(wvec1[i].oh));
      chk($sformatf("w3_mask_w%0d", wvec1[i].way), 32'(mask1), 32'(wvec1[i].mask));
    end

    // Mid-cycle async reset at count 2, with up held through reset.
    step('{1'b0, 1'b1, 1, 1'b0, 1'b0, "pre_rst1"});
    step('{1'b0, 1'b1, 2, 1'b0, 1'b0, "pre_rst2"});
    #2;
    reset_n = 1'b0;
    up = 1'b1;
    #1;
    chk("async_rst_count", 32'(cnt0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_up_count", 32'(cnt0), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_up_count", 32'(cnt0), 32'd1);
    up = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_hold", 32'(cnt0), 32'd1);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_way_mask_counter.md
# dma_way_mask_counter

Beat counter and way-select mask generator for the cache DMA engine. It combines three functions: a clear/up burst counter with end-of-burst flags, a one-hot decode of the selected way, and a byte-lane write mask for the data memory. The DMA state machine instantiates one copy to sequence fill and evict bursts and to build per-way write masks.

## Interface
- `max_val_p`, default 4: largest count value; usually the burst length.
- `init_val_p`, default 0: count value after reset and after clear; must be ≤ `max_val_p`.
- `ways_p`, default 4: number of ways decoded.
- `expand_p`, default 8: bytes per way lane; each one-hot bit is replicated this many times.
- Derived: `cw` = safe_clog2(`max_val_p`+1); `lw` = safe_clog2(`ways_p`). safe_clog2 returns at least 1.

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: asynchronous, active-low reset.
- `clear_i`, in, 1: load `init_val_p`.
- `up_i`, in, 1: increment by one.
- `count_o`, out, `cw`: current count (registered).
- `last_o`, out, 1: `count_o` == `max_val_p`-1 (fill end).
- `max_o`, out, 1: `count_o` == `max_val_p` (evict end).
- `way_i`, in, `lw`: selected way index.
- `way_onehot_o`, out, `ways_p`: one-hot decode of `way_i`.
- `way_mask_o`, out, `ways_p`*`expand_p`: bit `w*expand_p+k` = `way_onehot_o[w]`.

## Operation
- Next-count rule: next = (`clear_i` ? `init_val_p` : count) + `up_i`.
- `clear_i` together with `up_i` yields `init_val_p`+1; this is the evict-start case.
- `clear_i` alone yields `init_val_p`. Neither asserted: count holds.
- Overflow: `up_i` without `clear_i` while count == `max_val_p` wraps count to 0. This is the default build; see Configuration.
- Decode: bit `way_i` of `way_onehot_o` is set. If `way_i` ≥ `ways_p`, all bits are 0.
- Expand: `way_mask_o` is the bitwise replication of `way_onehot_o`, way 0 in the least-significant `expand_p` bits.
- `last_o` and `max_o` are decoded from the registered count. When `max_val_p` = 0, `last_o` is constant 0.

## Timing
- Count updates on the rising edge of `clk_i`; `count_o` reflects `clear_i`/`up_i` one cycle later.
- `last_o` and `max_o` are combinational from `count_o`, so they become valid in the same cycle `count_o` changes.
- Decode and expand are purely combinational, with zero cycles from `way_i` to `way_mask_o`. There is no handshake.
- Reset: `reset_n_i` low forces count to `init_val_p` immediately, without waiting for a clock edge.
  - While reset is held, `last_o` and `max_o` follow the reset count. `way_onehot_o` and `way_mask_o` keep following `way_i`.
  - Asserting reset mid-burst abandons the burst. The first edge after deassertion applies the normal update rule.
- `clear_i` and `up_i` asserted in the same cycle as reset deassertion are sampled normally on the next rising edge.

## Configuration
- Macro: `DMA_WAY_MASK_COUNTER_SATURATE_EN`.
- Defined: `up_i` at `max_val_p` (without `clear_i`) holds the count at `max_val_p`.
- Not defined: the count wraps to 0.
- `clear_i` behaviour is identical in both builds.

## Structure
- Shared package `dma_way_mask_pkg`:
  - `safe_clog2` function.
  - Default constants for burst length, ways and bytes per lane.
  - Typedef `way_mask_t` for the `ways_p` × `expand_p` packed mask.
- One natural sub-module, `way_mask_expand`: combinational bit replication with parameters `in_width_p` and `expand_p`. It is instantiated once.
- The counter and decoder stay inline in the top module.

## Test plan
- Reset, then 3 × `up_i` with defaults: `count_o` goes 0→1→2→3, and `last_o`=1 at count 3. A 4th up gives count 4 with `max_o`=1.
- At count 4: assert `clear_i`+`up_i` together → count 1. Assert `clear_i` alone → count 0.
- At count 4, `up_i` alone: count becomes 0 without the macro and stays 4 with `DMA_WAY_MASK_COUNTER_SATURATE_EN`.
- Sweep `way_i`=0..3 with defaults:
  - `way_onehot_o` = 0001, 0010, 0100, 1000.
  - `way_i`=2 gives `way_mask_o` = 0x00FF0000.
- `ways_p`=3, `way_i`=3 → `way_onehot_o`=000 and `way_mask_o`=0.
- Assert `reset_n_i` low mid-clock while at count 2 → `count_o`=`init_val_p` before the next edge. Hold `up_i` during reset → no increment until after deassertion.
